pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator that drives the board LEDs and other on/off loads, one independently programmable duty cycle per channel. A clock prescaler sets the PWM step rate. Each channel has a pending duty register that can be written at any time and is copied into its active register only at a period boundary, so outputs never glitch. An optional fade engine ramps selected channels up and down automatically.

## Interface
- `CLK_FREQ`, default 25_000_000: input clock frequency in Hz.
- `PWM_FREQ`, default 5: PWM period frequency in Hz.
- `CHANNELS`, default 8: number of PWM outputs, 1..32.
- `RES`, default 8: duty resolution in bits; one period is 2^RES steps.

- `clk`  in  1: single clock; every register is clocked on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `wr_en`  in  1: write strobe for a pending duty register.
- `wr_ch`  in  $clog2(CHANNELS) (minimum 1): channel index for the write; indices ≥ CHANNELS are ignored.
- `wr_duty`  in  RES+1: duty in steps, 0..2^RES; values above 2^RES saturate to 2^RES.
- `fade_en`  in  CHANNELS: per-channel fade select; used only when `PWM_FADE_EN` is defined.
- `pwm`  out  CHANNELS: registered PWM outputs.
- `period_start`  out  1: one-cycle pulse marking the first step of each period.

## Operation
- Prescaler:
  - DIV = CLK_FREQ / (PWM_FREQ · 2^RES), forced to a minimum of 1.
  - `div_cnt` counts 0..DIV-1. `tick` is asserted in the cycle where `div_cnt` = DIV-1.
- Step counter:
  - `step` is RES bits wide and advances by 1 on each tick.
  - It wraps from 2^RES-1 to 0.
  - `boundary` = tick AND `step` = 2^RES-1.
- Write handling:
  - `wr_en` with a valid `wr_ch` loads the pending register with the saturated `wr_duty` on the next edge.
  - A write never changes an output in the middle of a period.
- Active load:
  - On `boundary`, active[i] ← pending[i] for every channel.
  - If a write to channel i arrives in the same cycle as `boundary`, the write is bypassed: both pending[i] and active[i] receive the new value.
- Output: pwm[i] ← (`step` < active[i]), registered.
  - Duty 0 gives a constant 0.
  - Duty 2^RES gives a constant 1.
  - Duty d gives exactly d steps high per period.
- `period_start` ← `boundary`, registered. It goes high in the same cycle that `step` reads 0.
- Reset: `div_cnt`, `step`, all pending and active registers, `pwm`, `period_start` and the fade directions all become 0.
  - A reset mid-period aborts the period immediately, with no completion.
  - Reset has priority over a write in the same cycle.

## Timing
- Write to pending register: 1 cycle.
- Write to visible output: appears at the next period boundary, plus 1 cycle of registered-output latency.
- `step` to `pwm`: 1-cycle latency. Each step lasts DIV clocks, so the period is DIV·2^RES clocks.
- `period_start` is high for exactly 1 clock per period. The first pulse comes DIV·2^RES clocks after `rst` is released.
- There is no backpressure. Every write is accepted, and back-to-back writes to the same channel keep the last value written.

## Configuration
- Macro: `PWM_FADE_EN`.
- With the macro defined:
  - Each channel with fade_en[i]=1 ignores its pending register on `boundary`.
  - active[i] instead steps by 1 per period, with a per-channel direction bit:
    - It goes up toward 2^RES and turns to down when it reaches 2^RES.
    - It goes down toward 0 and turns to up when it reaches 0.
  - This gives a triangle from 0 to 2^RES and back over 2^(RES+1) periods.
  - Clearing fade_en[i] restores the pending-register load at the next boundary. The direction bit is held.
  - Writes to a fading channel still update its pending register.
- Without the macro:
  - The fade logic and direction bits are not built.
  - `fade_en` is ignored.
  - active[i] always loads from pending[i].

## Test plan
All scenarios use CLK_FREQ=160, PWM_FREQ=10, RES=4 and CHANNELS=4, which gives DIV=1 and a 16-clock period.
- Reset release → `pwm`=0000 and `period_start`=0; the first `period_start` pulse comes 16 clocks later, then one every 16 clocks.
- Write ch0=4, ch1=0, ch2=16, ch3=31 → after the next boundary:
  - ch0 is high 4 of 16 clocks.
  - ch1 stays 0.
  - ch2 stays 1.
  - ch3 saturates and stays 1.
- Write ch0=8 at step 3 of a period where ch0 is active at 4 → that period still shows 4 high clocks; the following period shows 8.
- Write ch1=5 in the exact boundary cycle → the very next period shows ch1 high for 5 clocks (bypass).
- Assert `rst` at step 7 while ch0=12 → `pwm` is 0 on the next edge; after release, ch0 stays 0 until it is rewritten and a boundary occurs.
- With `PWM_FADE_EN` defined, set fade_en[0]=1 from duty 0 → ch0 high-clock counts per period run 1,2,…,16,15,…,0,1, with the turnarounds at 16 and 0.

Source files
------------

// File: rtl/pwm_multi.sv
`default_nettype none
// =============================================================================
// pwm_multi : multi-channel PWM, glitch-free duty update at period boundaries.
// Optional fade engine enabled by defining PWM_FADE_EN.      Revision: 1.0
// =============================================================================
module pwm_multi #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int PWM_FREQ = 5,
  parameter int CHANNELS = 8,
  parameter int RES      = 8
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [RES:0]                                  wr_duty,
  input  logic [CHANNELS-1:0]                           fade_en,
  output logic [CHANNELS-1:0]                           pwm,
  output logic                                          period_start
);

  localparam int STEPS   = 2 ** RES;
  localparam int DIV_RAW = CLK_FREQ / (PWM_FREQ * STEPS);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [RES:0]     FULL     = (RES + 1)'(STEPS);

  logic [DIV_W-1:0]    div_cnt;
  logic [RES-1:0]      step;
  logic [RES:0]        pending [CHANNELS];
  logic [RES:0]        active  [CHANNELS];
  logic [CHANNELS-1:0] wr_hit;
  logic [RES:0]        duty_sat;
  logic                tick;
  logic                boundary;

  assign tick     = (div_cnt == DIV_LAST);
  assign boundary = tick && (step == {RES{1'b1}});
  assign duty_sat = wr_duty[RES] ? FULL : wr_duty;

  // Out-of-range channel indices match no channel and are thus dropped.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && (32'(wr_ch) == i);
    end
  end

`ifdef PWM_FADE_EN
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] dir_nxt;
  logic [RES:0]        fade_nxt [CHANNELS];

  // Triangle ramp: direction flips on the step that reaches either end.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      fade_nxt[i] = active[i];
      dir_nxt[i]  = dir[i];
      if (!dir[i]) begin
        if (active[i] >= FULL) begin
          fade_nxt[i] = FULL - 1'b1;
          dir_nxt[i]  = 1'b1;
        end else begin
          fade_nxt[i] = active[i] + 1'b1;
          dir_nxt[i]  = (active[i] == FULL - 1'b1);
        end
      end else begin
        if (active[i] == '0) begin
          fade_nxt[i] = (RES + 1)'(1);
          dir_nxt[i]  = 1'b0;
        end else begin
          fade_nxt[i] = active[i] - 1'b1;
          dir_nxt[i]  = (active[i] != (RES + 1)'(1));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (boundary && fade_en[i]) dir[i] <= dir_nxt[i];
      end
    end
  end
`else
  logic unused_fade;
  assign unused_fade = ^fade_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt      <= '0;
      step         <= '0;
      period_start <= 1'b0;
      pwm          <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        pending[i] <= '0;
        active[i]  <= '0;
      end
    end else begin
      div_cnt      <= tick ? '0 : div_cnt + 1'b1;
      period_start <= boundary;
      if (tick) step <= step + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
        pwm[i] <= ({1'b0, step} < active[i]);
        if (wr_hit[i]) pending[i] <= duty_sat;
        // A write landing on the boundary cycle bypasses straight to active.
        if (boundary) begin
`ifdef PWM_FADE_EN
          if (fade_en[i]) active[i] <= fade_nxt[i];
          else
`endif
          active[i] <= wr_hit[i] ? duty_sat : pending[i];
        end
      end
    end
  end

endmodule
`default_nettype wire
